// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage branch resolver: branch opcodes, FSM states
// and the condition-decode helpers used by branch_resolve.
package alu_pkg;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_BEQ   = 3'd1,
        BR_BNE   = 3'd2,
        BR_COND  = 3'd3,
        BR_NCOND = 3'd4,
        BR_JUMP  = 3'd5
    } br_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } br_state_t;

    // Offsets are in words; shift converts them to a byte displacement.
    localparam int BR_OFFSET_SHIFT = 2;

    function automatic logic br_counted(input logic [2:0] op);
        return (op >= BR_BEQ) && (op <= BR_JUMP);
    endfunction

    // NONE and the reserved encodings (6, 7) never take.
    function automatic logic br_taken(input logic [2:0] op, input logic cond, input logic z);
        logic t;
        case (op)
            BR_BEQ:   t = z;
            BR_BNE:   t = ~z;
            BR_COND:  t = cond;
            BR_NCOND: t = ~cond;
            BR_JUMP:  t = 1'b1;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolver: latches one request, decides taken from the ALU
// compare bit / Z flag, redirects fetch and holds a timed flush of younger stages.
module branch_resolve
    import alu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       br_op,
    input  logic [31:0]      alu_s,
    input  logic             alu_z,
    input  logic [31:0]      pc_plus4,
    input  logic [15:0]      offset,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ack,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_t          state, state_nxt;
    logic [3:0]         fcnt;

    logic [2:0]         op_p0;
    logic               cond_p0;
    logic               z_p0;
    logic [31:0]        pc4_p0;
    logic signed [15:0] off_p0;

    logic               taken_p1;
    logic [31:0]        target_p1;
    logic               branch_inc;
    logic               taken_inc;

    // Only the condition bit of the compare result matters here.
    logic               unused_alu_hi;
    assign unused_alu_hi = ^alu_s[31:1];

    // Word offset is sign-extended before scaling; the add wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic signed [15:0] off);
        logic signed [31:0] off_ext;
        off_ext = 32'(off);
        return pc + (off_ext <<< BR_OFFSET_SHIFT);
    endfunction

    // Stage p0: request capture in IDLE
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            op_p0   <= br_op;
            cond_p0 <= alu_s[0];
            z_p0    <= alu_z;
            pc4_p0  <= pc_plus4;
            off_p0  <= offset;
        end
    end

    // Stage p1: evaluation in EVAL
    always_comb begin
        taken_p1   = br_taken(op_p0, cond_p0, z_p0);
        target_p1  = branch_target(pc4_p0, off_p0);
        branch_inc = (state == ST_EVAL) && br_counted(op_p0);
        taken_inc  = (state == ST_EVAL) && taken_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (in_valid) state_nxt = ST_EVAL;
            ST_EVAL:     state_nxt = taken_p1 ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: if (redir_ack) state_nxt = ST_FLUSH;
            ST_FLUSH:    if (fcnt <= 4'd1) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Flush countdown starts on the accepted redirect, not on its request.
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt <= '0;
        end else if (state == ST_REDIRECT && redir_ack) begin
            fcnt <= 4'(FLUSH_CYCLES);
        end else if (state == ST_FLUSH && fcnt != 4'd0) begin
            fcnt <= fcnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redir_pc <= '0;
        end else if (taken_inc) begin
            redir_pc <= target_p1;
        end
    end

    assign in_ready    = (state == ST_IDLE) && !reset;
    assign redir_valid = (state == ST_REDIRECT);
    assign flush       = (state == ST_REDIRECT) || (state == ST_FLUSH);

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_inc),
        .count (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (taken_inc),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed and random branches against a reference
// model, reset aborts, and a narrow-counter instance driven into saturation.
module tb_branch_resolve;

    localparam int FC  = 2;
    localparam int SFC = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [2:0]  br_op = '0;
    logic [31:0] alu_s = '0;
    logic        alu_z = 1'b0;
    logic [31:0] pc_plus4 = '0;
    logic [15:0] offset = '0;
    logic        redir_valid, flush;
    logic [31:0] redir_pc;
    logic        redir_ack = 1'b0;
    logic [15:0] branch_cnt, taken_cnt;

    logic        s_in_valid = 1'b0, s_in_ready;
    logic [2:0]  s_br_op = '0;
    logic [31:0] s_alu_s = '0;
    logic        s_alu_z = 1'b0;
    logic [31:0] s_pc_plus4 = '0;
    logic [15:0] s_offset = '0;
    logic        s_redir_valid, s_flush;
    logic [31:0] s_redir_pc;
    logic        s_redir_ack = 1'b0;
    logic [3:0]  s_branch_cnt, s_taken_cnt;

    int vectors = 0;
    int miscompares = 0;

    int          m_br = 0, m_tk = 0;
    logic [31:0] m_pc = '0;
    int          s_br = 0, s_tk = 0;

    branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .br_op(br_op), .alu_s(alu_s), .alu_z(alu_z), .pc_plus4(pc_plus4),
        .offset(offset), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .redir_ack(redir_ack), .flush(flush), .branch_cnt(branch_cnt),
        .taken_cnt(taken_cnt)
    );

    branch_resolve #(.FLUSH_CYCLES(SFC), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .br_op(s_br_op), .alu_s(s_alu_s), .alu_z(s_alu_z), .pc_plus4(s_pc_plus4),
        .offset(s_offset), .redir_valid(s_redir_valid), .redir_pc(s_redir_pc),
        .redir_ack(s_redir_ack), .flush(s_flush), .branch_cnt(s_branch_cnt),
        .taken_cnt(s_taken_cnt)
    );

    function automatic bit model_taken(input int op, input bit c, input bit z);
        case (op)
            1: return z;
            2: return !z;
            3: return c;
            4: return !c;
            5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc4, input logic [15:0] off);
        longint o, t;
        o = longint'($signed(off));
        t = longint'(pc4) + o * 4;
        return t[31:0];
    endfunction

    // Drives one request into dut (called 1ns after a rising edge with in_ready high)
    // and records what the outputs did until in_ready returns.
    task automatic run_branch(input logic [2:0] op, input logic [31:0] s, input logic z,
                              input logic [31:0] pc4, input logic [15:0] off,
                              input int ack_d, input bit junk,
                              output bit got_rv, output int rv_lat, output logic [31:0] pc_seen,
                              output bit stable, output int flush_n, output int ready_lat,
                              output logic flush_at_ready);
        got_rv = 0; rv_lat = -1; pc_seen = '0; stable = 1; flush_n = 0;
        ready_lat = -1; flush_at_ready = 1'bx;
        in_valid = 1'b1; br_op = op; alu_s = s; alu_z = z;
        pc_plus4 = pc4; offset = off; redir_ack = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (redir_valid) begin
                if (!got_rv) begin
                    got_rv = 1; rv_lat = k; pc_seen = redir_pc;
                end else if (redir_pc !== pc_seen) begin
                    stable = 0;
                end
            end
            if (flush) flush_n++;
            if (in_ready) begin
                ready_lat = k; flush_at_ready = flush;
                in_valid = 1'b0; redir_ack = 1'b0;
                break;
            end
            in_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            if (junk) begin
                br_op = 3'($urandom_range(1, 5)); alu_s = $urandom; alu_z = 1'($urandom);
                pc_plus4 = $urandom; offset = 16'($urandom);
            end
            redir_ack = redir_valid ? ((k - rv_lat) >= ack_d) : 1'($urandom_range(0, 1));
        end
        if (ready_lat < 0) in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL reset redir_valid: got %b want 0", redir_valid); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL reset flush: got %b want 0", flush); end
        vectors++; if (redir_pc !== 32'h0) begin miscompares++; $display("FAIL reset redir_pc: got %h want 0", redir_pc); end
        vectors++; if (branch_cnt !== 16'h0 || taken_cnt !== 16'h0) begin miscompares++; $display("FAIL reset counters: got %0d/%0d want 0/0", branch_cnt, taken_cnt); end
        reset = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset release in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [6];
        logic [31:0] t_s  [6];
        logic        t_z  [6];
        logic [31:0] t_pc [6];
        logic [15:0] t_off[6];
        int          t_d  [6];
        bit got_rv, stable, exp_t;
        int rv_lat, flush_n, ready_lat;
        logic [31:0] pc_seen, exp_pc;
        logic flush_at_ready;
        t_op[0] = 3'd1; t_s[0] = 32'h0; t_z[0] = 1'b1; t_pc[0] = 32'h0000_1000; t_off[0] = 16'h0004; t_d[0] = 0;
        t_op[1] = 3'd3; t_s[1] = 32'h0; t_z[1] = 1'b0; t_pc[1] = 32'h0000_2000; t_off[1] = 16'hFFFF; t_d[1] = 0;
        t_op[2] = 3'd4; t_s[2] = 32'h0; t_z[2] = 1'b0; t_pc[2] = 32'h0000_0004; t_off[2] = 16'hFFFE; t_d[2] = 5;
        t_op[3] = 3'd6; t_s[3] = 32'h1; t_z[3] = 1'b1; t_pc[3] = 32'h0000_0100; t_off[3] = 16'h0010; t_d[3] = 0;
        t_op[4] = 3'd0; t_s[4] = 32'h1; t_z[4] = 1'b1; t_pc[4] = 32'h0000_0200; t_off[4] = 16'h0020; t_d[4] = 0;
        t_op[5] = 3'd2; t_s[5] = 32'h0; t_z[5] = 1'b0; t_pc[5] = 32'h8000_0000; t_off[5] = 16'h7FFF; t_d[5] = 1;
        for (int i = 0; i < 6; i++) begin
            run_branch(t_op[i], t_s[i], t_z[i], t_pc[i], t_off[i], t_d[i], 1'b0,
                       got_rv, rv_lat, pc_seen, stable, flush_n, ready_lat, flush_at_ready);
            exp_t  = model_taken(int'(t_op[i]), t_s[i][0], t_z[i]);
            exp_pc = model_target(t_pc[i], t_off[i]);
            if (t_op[i] >= 3'd1 && t_op[i] <= 3'd5) m_br++;
            if (exp_t) begin m_tk++; m_pc = exp_pc; end
            vectors++; if (got_rv !== exp_t) begin miscompares++; $display("FAIL dir%0d redirect: got %0b want %0b", i, got_rv, exp_t); end
            if (exp_t) begin
                vectors++; if (rv_lat !== 2) begin miscompares++; $display("FAIL dir%0d redir latency: got %0d want 2", i, rv_lat); end
                vectors++; if (pc_seen !== exp_pc) begin miscompares++; $display("FAIL dir%0d redir_pc: got %h want %h", i, pc_seen, exp_pc); end
                vectors++; if (stable !== 1'b1) begin miscompares++; $display("FAIL dir%0d redir_pc stable: got %0b want 1", i, stable); end
                vectors++; if (flush_n !== 1 + t_d[i] + FC) begin miscompares++; $display("FAIL dir%0d flush cycles: got %0d want %0d", i, flush_n, 1 + t_d[i] + FC); end
                vectors++; if (ready_lat !== 3 + t_d[i] + FC) begin miscompares++; $display("FAIL dir%0d ready latency: got %0d want %0d", i, ready_lat, 3 + t_d[i] + FC); end
            end else begin
                vectors++; if (flush_n !== 0) begin miscompares++; $display("FAIL dir%0d flush cycles: got %0d want 0", i, flush_n); end
                vectors++; if (ready_lat !== 2) begin miscompares++; $display("FAIL dir%0d ready latency: got %0d want 2", i, ready_lat); end
            end
            vectors++; if (flush_at_ready !== 1'b0) begin miscompares++; $display("FAIL dir%0d flush in idle: got %b want 0", i, flush_at_ready); end
            vectors++; if (redir_pc !== m_pc) begin miscompares++; $display("FAIL dir%0d redir_pc held: got %h want %h", i, redir_pc, m_pc); end
            vectors++; if (branch_cnt !== 16'(m_br)) begin miscompares++; $display("FAIL dir%0d branch_cnt: got %0d want %0d", i, branch_cnt, m_br); end
            vectors++; if (taken_cnt !== 16'(m_tk)) begin miscompares++; $display("FAIL dir%0d taken_cnt: got %0d want %0d", i, taken_cnt, m_tk); end
        end
    endtask

    task automatic test_random_traffic();
        bit got_rv, stable, exp_t;
        int rv_lat, flush_n, ready_lat, d;
        logic [31:0] pc_seen, exp_pc, s, pc4;
        logic [15:0] off;
        logic [2:0] op;
        logic z, flush_at_ready;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7)); s = $urandom; z = 1'($urandom);
            pc4 = $urandom; off = 16'($urandom); d = $urandom_range(0, 3);
            run_branch(op, s, z, pc4, off, d, 1'b1,
                       got_rv, rv_lat, pc_seen, stable, flush_n, ready_lat, flush_at_ready);
            exp_t  = model_taken(int'(op), s[0], z);
            exp_pc = model_target(pc4, off);
            if (op >= 3'd1 && op <= 3'd5) m_br++;
            if (exp_t) begin m_tk++; m_pc = exp_pc; end
            vectors++; if (got_rv !== exp_t) begin miscompares++; $display("FAIL rnd%0d redirect op=%0d: got %0b want %0b", i, op, got_rv, exp_t); end
            if (exp_t) begin
                vectors++; if (rv_lat !== 2) begin miscompares++; $display("FAIL rnd%0d redir latency: got %0d want 2", i, rv_lat); end
                vectors++; if (pc_seen !== exp_pc) begin miscompares++; $display("FAIL rnd%0d redir_pc: got %h want %h", i, pc_seen, exp_pc); end
                vectors++; if (stable !== 1'b1) begin miscompares++; $display("FAIL rnd%0d redir_pc stable: got %0b want 1", i, stable); end
                vectors++; if (flush_n !== 1 + d + FC) begin miscompares++; $display("FAIL rnd%0d flush cycles: got %0d want %0d", i, flush_n, 1 + d + FC); end
                vectors++; if (ready_lat !== 3 + d + FC) begin miscompares++; $display("FAIL rnd%0d ready latency: got %0d want %0d", i, ready_lat, 3 + d + FC); end
            end else begin
                vectors++; if (flush_n !== 0) begin miscompares++; $display("FAIL rnd%0d flush cycles: got %0d want 0", i, flush_n); end
                vectors++; if (ready_lat !== 2) begin miscompares++; $display("FAIL rnd%0d ready latency: got %0d want 2", i, ready_lat); end
            end
            vectors++; if (flush_at_ready !== 1'b0) begin miscompares++; $display("FAIL rnd%0d flush in idle: got %b want 0", i, flush_at_ready); end
            vectors++; if (redir_pc !== m_pc) begin miscompares++; $display("FAIL rnd%0d redir_pc held: got %h want %h", i, redir_pc, m_pc); end
            vectors++; if (branch_cnt !== 16'(m_br)) begin miscompares++; $display("FAIL rnd%0d branch_cnt: got %0d want %0d", i, branch_cnt, m_br); end
            vectors++; if (taken_cnt !== 16'(m_tk)) begin miscompares++; $display("FAIL rnd%0d taken_cnt: got %0d want %0d", i, taken_cnt, m_tk); end
        end
    endtask

    task automatic test_reset_mid(input bit in_flush);
        bit seen;
        int leaks;
        seen = 0; leaks = 0;
        in_valid = 1'b1; br_op = 3'd5; pc_plus4 = $urandom; offset = 16'($urandom); redir_ack = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (redir_valid) seen = 1;
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL rst_mid%0d reach redirect: got %0b want 1", in_flush, seen); end
        if (in_flush) begin
            redir_ack = 1'b1;
            @(posedge clk); #1;
            redir_ack = 1'b0;
            vectors++; if (flush !== 1'b1 || redir_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid1 in flush state: got flush=%b rv=%b want 1/0", flush, redir_valid); end
        end
        reset = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid%0d in_ready during reset: got %b want 0", in_flush, in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        m_br = 0; m_tk = 0; m_pc = '0; s_br = 0; s_tk = 0;
        vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid%0d redir_valid: got %b want 0", in_flush, redir_valid); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_mid%0d flush: got %b want 0", in_flush, flush); end
        vectors++; if (branch_cnt !== 16'h0 || taken_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_mid%0d counters: got %0d/%0d want 0/0", in_flush, branch_cnt, taken_cnt); end
        vectors++; if (redir_pc !== 32'h0) begin miscompares++; $display("FAIL rst_mid%0d redir_pc: got %h want 0", in_flush, redir_pc); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid%0d in_ready after reset: got %b want 1", in_flush, in_ready); end
        for (int k = 0; k < 5; k++) begin
            redir_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (redir_valid !== 1'b0 || flush !== 1'b0) leaks++;
        end
        redir_ack = 1'b0;
        vectors++; if (leaks !== 0) begin miscompares++; $display("FAIL rst_mid%0d late redirect cycles: got %0d want 0", in_flush, leaks); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] pc;
            logic [15:0] off;
            int lat;
            pc = $urandom; off = 16'($urandom); lat = -1;
            s_in_valid = 1'b1; s_br_op = 3'd5; s_pc_plus4 = pc; s_offset = off;
            s_alu_s = $urandom; s_alu_z = 1'($urandom); s_redir_ack = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (s_in_ready) begin lat = k; s_in_valid = 1'b0; break; end
                s_in_valid = 1'($urandom_range(0, 1));
            end
            s_in_valid = 1'b0;
            if (s_br < 15) s_br++;
            if (s_tk < 15) s_tk++;
            vectors++; if (lat !== 3 + SFC) begin miscompares++; $display("FAIL sat%0d ready latency: got %0d want %0d", i, lat, 3 + SFC); end
            vectors++; if (s_redir_pc !== model_target(pc, off)) begin miscompares++; $display("FAIL sat%0d redir_pc: got %h want %h", i, s_redir_pc, model_target(pc, off)); end
            vectors++; if (s_branch_cnt !== 4'(s_br)) begin miscompares++; $display("FAIL sat%0d branch_cnt: got %0d want %0d", i, s_branch_cnt, s_br); end
            vectors++; if (s_taken_cnt !== 4'(s_tk)) begin miscompares++; $display("FAIL sat%0d taken_cnt: got %0d want %0d", i, s_taken_cnt, s_tk); end
        end
        s_redir_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_traffic();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_directed();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
